bc_stream_arbiter: RTL and testbench
====================================

// Module: bc_stream_arbiter
// PURPOSE
//  Round-robin, burst-locked arbiter that shares the 16-bit breadcrumb buffer's write port between two producers.
//  Producer 0 is the avoidance breadcrumb source; producer 1 is the PWM command source.
//  The merged stream drives the buffer's inbound valid/ready port through a one-entry output register.
//  Each word carries its source ID so downstream logic can demultiplex it.
// PARAMETERS
//  DATA_W     16  word width of every data port
//  MAX_BURST   4  max words accepted per grant before re-arbitration (>=1)
// PORTS
//  clk        in   1       system clock, all logic on rising edge
//  rst        in   1       asynchronous, active-high reset
//  en         in   1       1 = arbitration allowed; 0 = no new grants
//  s0_valid   in   1       producer 0 word valid
//  s0_data    in   DATA_W  producer 0 word
//  s0_rdy     out  1       producer 0 word accepted this cycle when s0_valid=1
//  s1_valid   in   1       producer 1 word valid
//  s1_data    in   DATA_W  producer 1 word
//  s1_rdy     out  1       producer 1 word accepted this cycle when s1_valid=1
//  m_valid    out  1       output register holds a word
//  m_data     out  DATA_W  output word (to buffer din)
//  m_src      out  1       source ID of m_data (0/1)
//  m_rdy      in   1       buffer can take word (i.e. buffer not full)
//  busy       out  1       state != IDLE or m_valid=1
// BEHAVIOUR
//  Reset values
//   - state=IDLE, last_grant=1 (producer 0 wins first), burst_cnt=0.
//   - m_valid=0, m_data=0, m_src=0, s0_rdy=s1_rdy=0.
//   - Reset mid-operation discards the buffered word and any open burst.
//  Handshake
//   - AMBA-style valid/ready on every port; a transfer occurs when valid&rdy in the same cycle.
//   - space = ~m_valid | m_rdy.
//   - sN_rdy = (state==GRANTn) & space (combinational from state/m_valid/m_rdy only).
//   - sN_rdy does not depend on sN_valid.
//  Output register
//   - On accept: m_data<=sN_data, m_src<=n, m_valid<=1.
//   - Else if m_rdy: m_valid<=0.
//   - Latency: 1 cycle from accept to m_valid.
//   - Throughput: 1 word/clk while m_rdy=1.
//   - m_data and m_src are held stable while m_valid & ~m_rdy.
//  FSM states
//   - IDLE, GRANT0, GRANT1.
//  IDLE
//   - If en and any sN_valid: go to GRANTn, burst_cnt<=0.
//   - If both are valid: pick n = ~last_grant.
//   - Entering GRANTn sets last_grant<=n. No accept occurs in IDLE (1-cycle arbitration bubble).
//  GRANTn
//   - Each accept increments burst_cnt.
//   - Release after accept when burst_cnt+1==MAX_BURST.
//   - Release when sN_valid=0 and no accept (producer gap).
//   - Release when en=0: the in-flight accept completes, then release.
//   - Holding with ~space and sN_valid=1 is not a release.
//  On release
//   - If en and the other producer is valid: go directly to GRANT(other), burst_cnt<=0.
//   - Else if en and sN_valid (burst end only): go to GRANTn again, burst_cnt<=0.
//   - Else: go to IDLE.
//  Counter
//   - burst_cnt is $clog2(MAX_BURST+1) bits and never wraps. It is cleared on every grant entry.
//   - MAX_BURST=1 gives strict word-by-word alternation when both producers are valid.
//  Simultaneous events
//   - Both valid in IDLE: round-robin.
//   - An m_rdy drop during a burst stalls the accept; the grant is held and burst_cnt is unchanged.
//  Invariants
//   - s0_rdy and s1_rdy are never both 1.
//   - No word is lost or duplicated.
//   - Per-source order is preserved.
// TESTING
//  1. Reset: assert rst mid-burst -> m_valid=0, s0_rdy=s1_rdy=0 immediately; after release, first grant goes to s0.
//  2. Both producers hold valid, MAX_BURST=4, m_rdy=1:
//     - m_src sequence is 0,0,0,0,1,1,1,1,0...
//     - Data streams arrive in per-source order.
//  3. Only s1 valid with words 0xA001..0xA00A:
//     - All 10 appear on m_data in order with m_src=1.
//     - There is only the initial IDLE bubble; back-to-back re-grants add no gap.
//  4. Backpressure: hold m_rdy=0 for 5 clks mid-burst.
//     - m_data is stable and sN_rdy=0.
//     - burst_cnt is frozen; the burst resumes with no loss or duplication.
//  5. s0 drops valid after 2 words while s1 is valid:
//     - The grant moves to s1 on the next cycle.
//     - m_src order is 0,0,1...
//  6. en=0 mid-burst: the current word completes, state reaches IDLE, and busy falls once m_valid drains.

Source files
------------

// File: rtl/bc_stream_arbiter.sv
// Round-robin, burst-locked arbiter merging two valid/ready producers into one
// registered output stream tagged with the source ID of each word.
module bc_stream_arbiter #(
  parameter int DATA_W    = 16,
  parameter int MAX_BURST = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              en,
  input  logic              s0_valid,
  input  logic [DATA_W-1:0] s0_data,
  output logic              s0_rdy,
  input  logic              s1_valid,
  input  logic [DATA_W-1:0] s1_data,
  output logic              s1_rdy,
  output logic              m_valid,
  output logic [DATA_W-1:0] m_data,
  output logic              m_src,
  input  logic              m_rdy,
  output logic              busy
);

  localparam int CNT_W = $clog2(MAX_BURST + 1);
  localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(MAX_BURST - 1);

  typedef enum logic [1:0] {IDLE, GRANT0, GRANT1} state_t;

  state_t           state;
  logic             last_grant;
  logic [CNT_W-1:0] burst_cnt;

  logic space;
  logic acc0;
  logic acc1;
  logic cur_id;
  logic cur_valid;
  logic oth_valid;
  logic cur_acc;
  logic burst_end;
  logic release_now;
  logic idle_pick;

  assign space  = ~m_valid | m_rdy;
  assign s0_rdy = (state == GRANT0) & space;
  assign s1_rdy = (state == GRANT1) & space;
  assign busy   = (state != IDLE) | m_valid;

  // A burst ends on its last accept, on a producer gap, or as soon as en drops
  // (an accept in that same cycle still goes through).
  always_comb begin
    acc0        = s0_rdy & s0_valid;
    acc1        = s1_rdy & s1_valid;
    cur_id      = (state == GRANT1);
    cur_valid   = cur_id ? s1_valid : s0_valid;
    oth_valid   = cur_id ? s0_valid : s1_valid;
    cur_acc     = acc0 | acc1;
    burst_end   = cur_acc & (burst_cnt == LAST_CNT);
    release_now = burst_end | (~cur_valid & ~cur_acc) | ~en;
    idle_pick   = (s0_valid & s1_valid) ? ~last_grant : s1_valid;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state      <= IDLE;
      last_grant <= 1'b1;
      burst_cnt  <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (en && (s0_valid || s1_valid)) begin
            state      <= idle_pick ? GRANT1 : GRANT0;
            last_grant <= idle_pick;
            burst_cnt  <= '0;
          end
        end
        GRANT0, GRANT1: begin
          if (release_now) begin
            burst_cnt <= '0;
            if (en && oth_valid) begin
              state      <= cur_id ? GRANT0 : GRANT1;
              last_grant <= ~cur_id;
            end else if (en && cur_valid && burst_end) begin
              state      <= cur_id ? GRANT1 : GRANT0;
              last_grant <= cur_id;
            end else begin
              state <= IDLE;
            end
          end else if (cur_acc) begin
            burst_cnt <= burst_cnt + 1'b1;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  // One-entry output register; contents are held while the buffer stalls.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      m_valid <= 1'b0;
      m_data  <= '0;
      m_src   <= 1'b0;
    end else if (acc0) begin
      m_valid <= 1'b1;
      m_data  <= s0_data;
      m_src   <= 1'b0;
    end else if (acc1) begin
      m_valid <= 1'b1;
      m_data  <= s1_data;
      m_src   <= 1'b1;
    end else if (m_rdy) begin
      m_valid <= 1'b0;
    end
  end

endmodule

// File: tb/tb_bc_stream_arbiter.sv
// Randomized and directed bench for bc_stream_arbiter with a per-source scoreboard
// and a round-robin / burst-length rule checker.
module tb_bc_stream_arbiter;

  localparam int DATA_W    = 16;
  localparam int MAX_BURST = 4;

  logic              clk = 1'b0;
  logic              rst;
  logic              en;
  logic              s0_valid;
  logic [DATA_W-1:0] s0_data;
  logic              s0_rdy;
  logic              s1_valid;
  logic [DATA_W-1:0] s1_data;
  logic              s1_rdy;
  logic              m_valid;
  logic [DATA_W-1:0] m_data;
  logic              m_src;
  logic              m_rdy;
  logic              busy;

  bc_stream_arbiter #(.DATA_W(DATA_W), .MAX_BURST(MAX_BURST)) dut (
    .clk(clk), .rst(rst), .en(en),
    .s0_valid(s0_valid), .s0_data(s0_data), .s0_rdy(s0_rdy),
    .s1_valid(s1_valid), .s1_data(s1_data), .s1_rdy(s1_rdy),
    .m_valid(m_valid), .m_data(m_data), .m_src(m_src), .m_rdy(m_rdy),
    .busy(busy)
  );

  always #5 clk = ~clk;

  int checks   = 0;
  int failures = 0;
  int cycle_no = 0;

  logic [DATA_W-1:0] q0[$];
  logic [DATA_W-1:0] q1[$];
  logic [DATA_W-1:0] exp0[$];
  logic [DATA_W-1:0] exp1[$];
  int src_log[$];
  int out_cyc[$];

  int valid_pct;
  int rdy_pct;
  int stall_left;
  int stall_after;
  bit took0, took1;
  int acc0_n, acc1_n;

  bit                hold_valid;
  logic [DATA_W-1:0] hold_data;
  logic              hold_src;

  int run_src, run_len, must_sw;
  bit vlow0, vlow1;

  task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] want);
    checks++;
    if (got !== want) begin
      failures++;
      $display("[TB] FAIL %s: got 0x%0h expected 0x%0h", tag, got, want);
    end
  endtask

  // Producers keep valid asserted until their word is taken.
  task automatic applyStimulus();
    if (!s0_valid || took0) s0_valid = (q0.size() > 0) && (int'($urandom_range(99)) < valid_pct);
    if (!s1_valid || took1) s1_valid = (q1.size() > 0) && (int'($urandom_range(99)) < valid_pct);
    s0_data = (q0.size() > 0) ? q0[0] : '0;
    s1_data = (q1.size() > 0) ? q1[0] : '0;
    if (stall_left > 0) begin
      m_rdy = 1'b0;
      stall_left--;
    end else begin
      m_rdy = int'($urandom_range(99)) < rdy_pct;
    end
    took0 = 1'b0;
    took1 = 1'b0;
  endtask

  task automatic noteAccept(input int n, input bit other_v);
    bit gap;
    if (must_sw >= 0) begin
      checkOutput("rr_switch", n, must_sw);
      must_sw = -1;
    end
    gap = (n == 1) ? vlow1 : vlow0;
    if (n == run_src && !gap) run_len++;
    else run_len = 1;
    run_src = n;
    if (n == 1) vlow1 = 1'b0;
    else vlow0 = 1'b0;
    if (run_len == MAX_BURST) begin
      if (other_v && en) must_sw = 1 - n;
      run_len = 0;
    end
  endtask

  task automatic cycle();
    @(negedge clk);
    checkOutput("rdy_excl", {31'b0, s0_rdy & s1_rdy}, 32'd0);
    if (hold_valid) begin
      checkOutput("hold_data", m_data, hold_data);
      checkOutput("hold_src", m_src, hold_src);
    end
    hold_valid = m_valid && !m_rdy;
    hold_data  = m_data;
    hold_src   = m_src;
    if (m_valid && !m_rdy) checkOutput("stall_rdy", {31'b0, s0_rdy | s1_rdy}, 32'd0);
    if (m_valid && m_rdy) begin
      if (m_src == 1'b0) begin
        if (exp0.size() == 0) checkOutput("dup0", 1, 0);
        else checkOutput("data0", m_data, exp0.pop_front());
      end else begin
        if (exp1.size() == 0) checkOutput("dup1", 1, 0);
        else checkOutput("data1", m_data, exp1.pop_front());
      end
      src_log.push_back(int'(m_src));
      out_cyc.push_back(cycle_no);
      if (stall_after >= 0 && src_log.size() == stall_after) begin
        stall_left  = 5;
        stall_after = -1;
      end
    end
    if (!s0_valid) vlow0 = 1'b1;
    if (!s1_valid) vlow1 = 1'b1;
    if (s0_valid && s0_rdy) begin
      exp0.push_back(q0.pop_front());
      took0 = 1'b1;
      acc0_n++;
      noteAccept(0, s1_valid);
    end
    if (s1_valid && s1_rdy) begin
      exp1.push_back(q1.pop_front());
      took1 = 1'b1;
      acc1_n++;
      noteAccept(1, s0_valid);
    end
    @(posedge clk);
    #1;
    applyStimulus();
    cycle_no++;
  endtask

  task automatic clearModel();
    q0.delete(); q1.delete(); exp0.delete(); exp1.delete();
    src_log.delete(); out_cyc.delete();
    s0_valid = 1'b0; s1_valid = 1'b0;
    took0 = 1'b0; took1 = 1'b0;
    hold_valid = 1'b0;
    run_src = -1; run_len = 0; must_sw = -1;
    vlow0 = 1'b1; vlow1 = 1'b1;
    acc0_n = 0; acc1_n = 0;
    stall_left = 0; stall_after = -1;
  endtask

  task automatic doReset();
    rst = 1'b1;
    clearModel();
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
  endtask

  task automatic load(input int n0, input logic [DATA_W-1:0] b0, input int n1,
                      input logic [DATA_W-1:0] b1, input bit rnd);
    for (int i = 0; i < n0; i++) q0.push_back(rnd ? DATA_W'($urandom) : b0 + DATA_W'(i));
    for (int i = 0; i < n1; i++) q1.push_back(rnd ? DATA_W'($urandom) : b1 + DATA_W'(i));
  endtask

  task automatic runUntil(input int n, input int budget);
    int k;
    k = 0;
    while (src_log.size() < n && k < budget) begin
      cycle();
      k++;
    end
    checkOutput("out_count", src_log.size(), n);
  endtask

  task automatic checkDrained();
    checkOutput("lost0", exp0.size(), 0);
    checkOutput("lost1", exp1.size(), 0);
  endtask

  initial begin
    #500000;
    $display("[TB] FAIL watchdog: simulation did not finish in time");
    $fatal(1, "[TB] watchdog");
  end

  initial begin
    int start;
    rst = 1'b1; en = 1'b1; m_rdy = 1'b1;
    s0_valid = 1'b0; s1_valid = 1'b0; s0_data = '0; s1_data = '0;
    valid_pct = 100; rdy_pct = 100;
    doReset();

    checkOutput("rst_m_valid", m_valid, 0);
    checkOutput("rst_m_data", m_data, 0);
    checkOutput("rst_m_src", m_src, 0);
    checkOutput("rst_s0_rdy", s0_rdy, 0);
    checkOutput("rst_s1_rdy", s1_rdy, 0);
    checkOutput("rst_busy", busy, 0);

    // Reset in the middle of a producer-0 burst; first grant afterwards must be s0.
    load(8, 16'h1000, 0, 16'h0, 1'b0);
    applyStimulus();
    runUntil(2, 20);
    #3 rst = 1'b1;
    #1;
    checkOutput("midrst_m_valid", m_valid, 0);
    checkOutput("midrst_s0_rdy", s0_rdy, 0);
    checkOutput("midrst_s1_rdy", s1_rdy, 0);
    doReset();
    load(2, 16'h3000, 2, 16'h4000, 1'b0);
    applyStimulus();
    runUntil(4, 30);
    if (src_log.size() > 0) checkOutput("first_grant_s0", src_log[0], 0);
    checkDrained();

    // Both producers saturated: bursts of MAX_BURST alternate with no gaps.
    doReset();
    load(16, 16'h1000, 16, 16'h2000, 1'b0);
    applyStimulus();
    start = cycle_no;
    runUntil(32, 100);
    for (int k = 0; k < src_log.size(); k++) begin
      checkOutput("rr_pattern", src_log[k], (k / MAX_BURST) % 2);
      checkOutput("rr_timing", out_cyc[k], start + 2 + k);
    end
    checkDrained();

    // Only s1 valid: one initial bubble, re-grants are seamless.
    doReset();
    load(0, 16'h0, 10, 16'hA001, 1'b0);
    applyStimulus();
    start = cycle_no;
    runUntil(10, 50);
    for (int k = 0; k < src_log.size(); k++) begin
      checkOutput("s1_only_src", src_log[k], 1);
      checkOutput("s1_only_timing", out_cyc[k], start + 2 + k);
    end
    checkDrained();

    // Backpressure for 5 clocks mid-burst; the burst count must stay frozen.
    doReset();
    load(8, 16'h1000, 8, 16'h2000, 1'b0);
    stall_after = 2;
    applyStimulus();
    runUntil(16, 100);
    for (int k = 0; k < src_log.size(); k++) checkOutput("stall_pattern", src_log[k], (k / MAX_BURST) % 2);
    if (out_cyc.size() > 2) checkOutput("stall_len", out_cyc[2] - out_cyc[1], 6);
    checkDrained();

    // s0 runs dry after 2 words while s1 waits.
    doReset();
    load(2, 16'h5000, 4, 16'h6000, 1'b0);
    applyStimulus();
    runUntil(6, 40);
    for (int k = 0; k < src_log.size(); k++) checkOutput("gap_pattern", src_log[k], (k < 2) ? 0 : 1);
    if (out_cyc.size() > 2) checkOutput("gap_timing", out_cyc[2] - out_cyc[1], 2);
    checkDrained();

    // en drops mid-burst: one more accept, then idle and busy falls.
    doReset();
    load(8, 16'h7000, 0, 16'h0, 1'b0);
    applyStimulus();
    runUntil(1, 20);
    en = 1'b0;
    for (int i = 0; i < 10; i++) begin
      cycle();
      if (!busy) break;
    end
    checkOutput("en0_busy_fall", busy, 0);
    repeat (3) cycle();
    checkOutput("en0_accepts", acc0_n, 3);
    checkOutput("en0_s0_rdy", s0_rdy, 0);
    checkOutput("en0_m_valid", m_valid, 0);
    en = 1'b1;
    runUntil(8, 60);
    checkDrained();

    // Random traffic and backpressure checked by the scoreboard and rule checker.
    doReset();
    valid_pct = 70;
    rdy_pct   = 75;
    load(150, 16'h0, 150, 16'h0, 1'b1);
    applyStimulus();
    for (int i = 0; i < 1200; i++) cycle();
    valid_pct = 100;
    rdy_pct   = 100;
    runUntil(300, 800);
    checkDrained();
    checkOutput("rand_q0_empty", q0.size(), 0);
    checkOutput("rand_q1_empty", q1.size(), 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
